// File: rtl/sram_1rw1r_sync_array_pkg.sv
// Shared constants and the lane-mask merge helper for the 1RW1R SRAM.
// Purpose: collision-mode encodings and a width-generic merge used by both
// the array write path and the port 1 write-through path.
package sram_1rw1r_sync_array_pkg;

    // Collision-mode encodings for COLL_MODE
    localparam int unsigned COLL_OLD = 0;
    localparam int unsigned COLL_NEW = 1;

    // Upper bound on word width the merge helper can handle
    localparam int unsigned MERGE_MAX_W = 1024;

    // Take lane i from din where lanes[i]=1, otherwise keep old.
    // Operands are zero-extended to MERGE_MAX_W by the caller.
    function automatic logic [MERGE_MAX_W-1:0] mask_merge(
        input logic [MERGE_MAX_W-1:0] din,
        input logic [MERGE_MAX_W-1:0] old,
        input logic [MERGE_MAX_W-1:0] lanes,
        input int unsigned            lane_w
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old;
        for (int unsigned b = 0; b < MERGE_MAX_W; b++) begin
            if (lanes[b / lane_w]) begin
                res[b] = din[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_1rw1r_sync_array_storage.sv
// Raw storage array: one lane-masked write port, two registered read ports.
// The array itself has no reset; only the read registers can be cleared.
// Ports:
//   clk0            clock
//   we/waddr/wmask/din   masked write (we must already exclude reset)
//   rd_clr          synchronous clear of both read registers
//   re0/raddr0/rdata0    read port 0, registered
//   re1/raddr1/rdata1    read port 1, registered
//   byp1            load rdata1 with din merged over the old word (write-through)
module sram_1rw1r_storage
    import sram_1rw1r_sync_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned WMASK_WIDTH = 8,
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH,
    localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WMASKS-1:0] wmask,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_clr,
    input  logic                  re0,
    input  logic [ADDR_WIDTH-1:0] raddr0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic                  byp1,
    output logic [DATA_WIDTH-1:0] rdata1
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] d,
        input logic [DATA_WIDTH-1:0] o,
        input logic [NUM_WMASKS-1:0] m
    );
        return DATA_WIDTH'(mask_merge(MERGE_MAX_W'(d), MERGE_MAX_W'(o),
                                      MERGE_MAX_W'(m), WMASK_WIDTH));
    endfunction

    // Masked write; unselected lanes keep their contents
    always_ff @(posedge clk0) begin
        if (we) begin
            mem[waddr] <= lane_merge(din, mem[waddr], wmask);
        end
    end

    // Read port 0: registered, holds when idle
    always_ff @(posedge clk0) begin
        if (rd_clr) begin
            rdata0 <= '0;
        end else if (re0) begin
            rdata0 <= mem[raddr0];
        end
    end

    // Read port 1: plain read returns pre-write contents; byp1 forwards the merge
    always_ff @(posedge clk0) begin
        if (rd_clr) begin
            rdata1 <= '0;
        end else if (re1) begin
            if (byp1) begin
                rdata1 <= lane_merge(din, mem[raddr1], wmask);
            end else begin
                rdata1 <= mem[raddr1];
            end
        end
    end

endmodule

// File: rtl/sram_1rw1r_sync_array.sv
// Synthesizable 1RW1R SRAM with lane write mask, optional output register,
// defined same-address read/write collision behaviour and a collision counter.
// Ports:
//   clk0, rstb0               clock, synchronous active-low reset
//   csb0, web0, wmask0, addr0, din0   port 0 (read/write) controls and data
//   dout0, dout0_valid        port 0 read data and one-cycle valid pulse
//   csb1, addr1               port 1 (read-only) controls
//   dout1, dout1_valid        port 1 read data and one-cycle valid pulse
//   coll1                     port 1 read collided with a port 0 write
//   coll_count                saturating collision count since reset
module sram_1rw1r_sync_array
    import sram_1rw1r_sync_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned WMASK_WIDTH    = 8,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned COLL_MODE      = 0,
    parameter int unsigned COLL_CNT_WIDTH = 16,
    localparam int unsigned NUM_WMASKS    = DATA_WIDTH / WMASK_WIDTH
) (
    input  logic                      clk0,
    input  logic                      rstb0,
    input  logic                      csb0,
    input  logic                      web0,
    input  logic [NUM_WMASKS-1:0]     wmask0,
    input  logic [ADDR_WIDTH-1:0]     addr0,
    input  logic [DATA_WIDTH-1:0]     din0,
    output logic [DATA_WIDTH-1:0]     dout0,
    output logic                      dout0_valid,
    input  logic                      csb1,
    input  logic [ADDR_WIDTH-1:0]     addr1,
    output logic [DATA_WIDTH-1:0]     dout1,
    output logic                      dout1_valid,
    output logic                      coll1,
    output logic [COLL_CNT_WIDTH-1:0] coll_count
);

    // Elaboration-time parameter sanity
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (DATA_WIDTH > MERGE_MAX_W) begin : g_bad_width
        $error("DATA_WIDTH exceeds MERGE_MAX_W");
    end
    if (OUT_REG > 1 || COLL_MODE > 1) begin : g_bad_mode
        $error("OUT_REG and COLL_MODE must be 0 or 1");
    end

    // Request decode; reset suppresses both writes and new reads
    logic wr_en, rd0_en, rd1_en, coll, byp1;
    assign wr_en  = rstb0 && !csb0 && !web0 && (|wmask0);
    assign rd0_en = rstb0 && !csb0 && web0;
    assign rd1_en = rstb0 && !csb1;
    assign coll   = rd1_en && wr_en && (addr0 == addr1);
    assign byp1   = coll && (COLL_MODE == COLL_NEW);

    logic [DATA_WIDTH-1:0] rdata0, rdata1;

    sram_1rw1r_storage #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WMASK_WIDTH (WMASK_WIDTH)
    ) u_storage (
        .clk0   (clk0),
        .we     (wr_en),
        .waddr  (addr0),
        .wmask  (wmask0),
        .din    (din0),
        .rd_clr (!rstb0),
        .re0    (rd0_en),
        .raddr0 (addr0),
        .rdata0 (rdata0),
        .re1    (rd1_en),
        .raddr1 (addr1),
        .byp1   (byp1),
        .rdata1 (rdata1)
    );

    // First pipeline stage: valids and collision flag aligned with rdata*
    logic rd0_v, rd1_v, coll_s1;
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            rd0_v      <= 1'b0;
            rd1_v      <= 1'b0;
            coll_s1    <= 1'b0;
            coll_count <= '0;
        end else begin
            rd0_v   <= rd0_en;
            rd1_v   <= rd1_en;
            coll_s1 <= coll;
            if (coll && (coll_count != '1)) begin
                coll_count <= coll_count + COLL_CNT_WIDTH'(1);
            end
        end
    end

    if (OUT_REG == 0) begin : g_lat1
        assign dout0       = rdata0;
        assign dout0_valid = rd0_v;
        assign dout1       = rdata1;
        assign dout1_valid = rd1_v;
        assign coll1       = coll_s1;
    end else begin : g_lat2
        // Extra output register; data only advances with its valid so dout holds
        always_ff @(posedge clk0) begin
            if (!rstb0) begin
                dout0       <= '0;
                dout1       <= '0;
                dout0_valid <= 1'b0;
                dout1_valid <= 1'b0;
                coll1       <= 1'b0;
            end else begin
                dout0_valid <= rd0_v;
                dout1_valid <= rd1_v;
                coll1       <= rd1_v && coll_s1;
                if (rd0_v) begin
                    dout0 <= rdata0;
                end
                if (rd1_v) begin
                    dout1 <= rdata1;
                end
            end
        end
    end

endmodule
